// File: rtl/rock_step_scheduler.sv
// Rocking-cradle step scheduler: applies one A/F step, lets the cradle settle, then waits for
// a stress drop and keeps or reverts the step.
module rock_step_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned EVAL_CYCLES   = 5000,
    parameter logic [2:0]  A_INIT        = 3'd7,
    parameter logic [2:0]  F_INIT        = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_down,
    input  logic       f_up,
    input  logic       f_down,
    input  logic       stress_dropped,
    input  logic       restart,
    output logic [2:0] A,
    output logic [2:0] F,
    output logic       busy,
    output logic       step_done,
    output logic       improved,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StSettle, StEval, StDone} state_t;

    localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] EvalLast   = 16'(EVAL_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  a_saved;
    logic [2:0]  f_saved;

    // Arbitrated request decode: at most one of req_ok / req_sat is set.
    logic       req_ok;
    logic       req_sat;
    logic [2:0] a_step;
    logic [2:0] f_step;

    always_comb begin
        req_ok  = 1'b0;
        req_sat = 1'b0;
        a_step  = A;
        f_step  = F;
        if (a_down) begin
            if (A == 3'd0) begin
                req_sat = 1'b1;
            end else begin
                req_ok = 1'b1;
                a_step = A - 3'd1;
            end
        end else if (f_down) begin
            if (F == 3'd0) begin
                req_sat = 1'b1;
            end else begin
                req_ok = 1'b1;
                f_step = F - 3'd1;
            end
        end else if (f_up) begin
            if (F == 3'd7) begin
                req_sat = 1'b1;
            end else begin
                req_ok = 1'b1;
                f_step = F + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= '0;
            A         <= A_INIT;
            F         <= F_INIT;
            a_saved   <= A_INIT;
            f_saved   <= F_INIT;
            busy      <= 1'b0;
            step_done <= 1'b0;
            improved  <= 1'b0;
            err       <= 1'b0;
        end else if (restart) begin
            // err is deliberately left alone: only reset clears it.
            state     <= StIdle;
            cnt       <= '0;
            A         <= A_INIT;
            F         <= F_INIT;
            busy      <= 1'b0;
            step_done <= 1'b0;
            improved  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_sat) begin
                        err <= 1'b1;
                    end else if (req_ok) begin
                        a_saved <= A;
                        f_saved <= F;
                        A       <= a_step;
                        F       <= f_step;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt == SettleLast) begin
                        cnt   <= '0;
                        state <= StEval;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StEval: begin
                    // A drop in the last EVAL cycle still counts as an improvement.
                    if (stress_dropped) begin
                        step_done <= 1'b1;
                        improved  <= 1'b1;
                        cnt       <= '0;
                        state     <= StDone;
                    end else if (cnt == EvalLast) begin
                        A         <= a_saved;
                        F         <= f_saved;
                        step_done <= 1'b1;
                        improved  <= 1'b0;
                        cnt       <= '0;
                        state     <= StDone;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StDone: begin
                    step_done <= 1'b0;
                    improved  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/rock_step_scheduler.md
ROCK_STEP_SCHEDULER -- requirements
Module: rock_step_scheduler

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1000, number of cycles the cradle settles after an A/F change (1..65535).
REQ-002 SHALL have parameter EVAL_CYCLES, default 5000, maximum number of cycles spent waiting for a stress drop (1..65535).
REQ-003 SHALL have parameter A_INIT, default 3'd7, amplitude after reset or restart.
REQ-004 SHALL have parameter F_INIT, default 3'd4, frequency after reset or restart.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_down  in  1  request to lower amplitude by one step (level).
- f_up  in  1  request to raise frequency by one step (level).
- f_down  in  1  request to lower frequency by one step (level).
- stress_dropped  in  1  baby stress has dropped (level).
- restart  in  1  synchronous return to initial A/F.
- A  out  3  amplitude setting.
- F  out  3  frequency setting.
- busy  out  1  step in progress.
- step_done  out  1  one-cycle pulse ending a step.
- improved  out  1  result of the step, valid while step_done=1.
- err  out  1  sticky error flag.

Function
REQ-006 SHALL implement FSM states IDLE, SETTLE, EVAL and DONE.
REQ-007 SHALL assert busy=1 in SETTLE, EVAL and DONE, and busy=0 in IDLE.
REQ-008 SHALL sample requests only in IDLE; requests in other states are ignored and are neither queued nor flagged.
REQ-009 SHALL arbitrate simultaneous requests with fixed priority a_down > f_down > f_up; lower-priority requests are dropped.
REQ-010 SHALL treat a_down at A=0, f_down at F=0 and f_up at F=7 as saturated: A/F unchanged, err set to 1, state stays IDLE, no step_done.
REQ-011 SHALL, for an accepted request, save the old A and F values, apply +/-1 to the selected output and enter SETTLE at the same edge; the new value is visible the cycle after the sampling edge.
REQ-012 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles using a 16-bit counter, ignoring stress_dropped, then enter EVAL with the counter cleared.
REQ-013 SHALL, in EVAL, enter DONE with improved=1 and keep the new A/F on the first cycle in which stress_dropped=1.
REQ-014 SHALL, if stress_dropped is not seen within EVAL_CYCLES EVAL cycles, restore the saved A/F at the edge leaving EVAL and enter DONE with improved=0.
REQ-015 SHALL give stress_dropped priority when it arrives in the final EVAL cycle (improved=1, no revert).
REQ-016 SHALL spend exactly one cycle in DONE with step_done=1 and improved valid, then return to IDLE.
REQ-017 SHALL hold step_done=0 and improved=0 outside DONE.
REQ-018 SHALL re-accept a request that is still held on the first IDLE cycle after DONE; requesters deassert on step_done.
REQ-019 SHALL let restart take priority over every other synchronous input: on the next edge A=A_INIT, F=F_INIT, state IDLE, counter 0, no step_done, err unchanged.
REQ-020 SHALL never wrap A or F; values stay in 0..7.

Reset
REQ-021 SHALL, while reset=0 and independent of clk, force state IDLE, counter 0, A=A_INIT, F=F_INIT, busy=0, step_done=0, improved=0 and err=0.
REQ-022 SHALL clear err only by reset.
REQ-023 SHALL abandon any step in progress when reset is asserted mid-step, with no revert and no step_done, the registers taking their reset values.

Verification (SETTLE_CYCLES=4, EVAL_CYCLES=8)
REQ-024 SHALL cover: a_down pulse in IDLE with A=7 -> A=6 the next cycle; busy for 4 SETTLE cycles; stress_dropped=1 on the 3rd EVAL cycle -> step_done=1, improved=1, A stays 6.
REQ-025 SHALL cover: f_up with F=4 and stress_dropped never asserted -> F=5 during SETTLE/EVAL; after 8 EVAL cycles F=4, step_done=1, improved=0.
REQ-026 SHALL cover: a_down, f_down and f_up asserted in the same IDLE cycle -> only A decrements, F unchanged.
REQ-027 SHALL cover: f_down with F=0 -> F stays 0, err=1, busy=0, no step_done; err stays 1 until reset.
REQ-028 SHALL cover: restart during EVAL after a_down (A=6) -> next cycle A=7, F=4, busy=0, no step_done.
REQ-029 SHALL cover: reset=0 asserted mid-SETTLE between clock edges -> outputs at reset values immediately; f_up while busy -> ignored.
